// File: rtl/alt_vipvfr131_common_plane_packer.sv
// alt_vipvfr131_common_plane_packer
// Packs a colour-plane-sequential stream (one plane per beat) into a
// colour-plane-parallel stream (one full sample per beat).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   sclr         synchronous clear, active-high (packet boundaries)
//   din_valid    input beat valid
//   din_ready    input beat accepted when din_valid & din_ready
//   din_data     one colour plane (BPS bits)
//   din_eop      last beat of packet
//   dout_valid   packed sample valid
//   dout_ready   downstream accepts sample
//   dout_data    packed sample, plane p in [p*BPS +: BPS], plane 0 in LSBs
//   dout_eop     sample carries end of packet
//   dout_partial sample flushed by eop before all planes arrived
//   plane_index  index of the next plane expected
module alt_vipvfr131_common_plane_packer #(
    parameter int BPS                          = 8,
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sclr,
    input  logic                                   din_valid,
    output logic                                   din_ready,
    input  logic [BPS-1:0]                         din_data,
    input  logic                                   din_eop,
    output logic                                   dout_valid,
    input  logic                                   dout_ready,
    output logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0] dout_data,
    output logic                                   dout_eop,
    output logic                                   dout_partial,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] plane_index
);

    localparam int N  = NUMBER_OF_COLOUR_PLANES;
    localparam int CW = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam int SW = BPS * N;
    localparam logic [CW-1:0] LAST_PLANE = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(32'd1);

    // The top lane of acc_r is never written and stays zero; keeping the
    // register full sample width makes the N==1 build need no special case.
    logic [CW-1:0]  cnt_r;
    logic [SW-1:0]  acc_r;
    logic           dout_valid_r;
    logic [SW-1:0]  dout_data_r;
    logic           dout_eop_r;
    logic           dout_partial_r;

    logic           din_ready_s;
    logic           accept_s;
    logic           last_plane_s;
    logic           complete_s;
    logic           out_hs_s;
    logic [SW-1:0]  sample_s;

    // Lanes below cnt come from the accumulator, lane cnt is the incoming
    // plane, lanes above cnt are zero (matters for eop-flushed samples).
    function automatic logic [SW-1:0] build_sample(
        input logic [SW-1:0]  acc,
        input logic [CW-1:0]  cnt,
        input logic [BPS-1:0] plane
    );
        logic [SW-1:0] s;
        s = '0;
        for (int p = 0; p < N; p++) begin
            if (CW'(p) < cnt) begin
                s[p*BPS +: BPS] = acc[p*BPS +: BPS];
            end else if (CW'(p) == cnt) begin
                s[p*BPS +: BPS] = plane;
            end else begin
                s[p*BPS +: BPS] = {BPS{1'b0}};
            end
        end
        return s;
    endfunction

    // Input may advance whenever the output slot is empty or being drained.
    assign din_ready_s  = rst & (~dout_valid_r | dout_ready);
    assign accept_s     = din_valid & din_ready_s;
    assign last_plane_s = (cnt_r == LAST_PLANE);
    assign complete_s   = accept_s & (din_eop | last_plane_s);
    assign out_hs_s     = dout_valid_r & dout_ready;

    // Candidate packed sample for a completing beat.
    always_comb begin
        sample_s = build_sample(acc_r, cnt_r, din_data);
    end

    // Plane counter, accumulator and output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r          <= '0;
            acc_r          <= '0;
            dout_valid_r   <= 1'b0;
            dout_data_r    <= '0;
            dout_eop_r     <= 1'b0;
            dout_partial_r <= 1'b0;
        end else if (sclr) begin
            // Any beat presented this cycle is dropped; partial planes are lost.
            cnt_r          <= '0;
            acc_r          <= '0;
            dout_valid_r   <= 1'b0;
            dout_data_r    <= '0;
            dout_eop_r     <= 1'b0;
            dout_partial_r <= 1'b0;
        end else if (complete_s) begin
            // Loads over any sample draining this cycle, so no bubble.
            dout_valid_r   <= 1'b1;
            dout_data_r    <= sample_s;
            dout_eop_r     <= din_eop;
            dout_partial_r <= din_eop & ~last_plane_s;
            cnt_r          <= '0;
            acc_r          <= '0;
        end else begin
            if (out_hs_s) begin
                dout_valid_r <= 1'b0;
            end else begin
                dout_valid_r <= dout_valid_r;
            end
            if (accept_s) begin
                for (int p = 0; p < N - 1; p++) begin
                    if (CW'(p) == cnt_r) begin
                        acc_r[p*BPS +: BPS] <= din_data;
                    end
                end
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign din_ready    = din_ready_s;
    assign dout_valid   = dout_valid_r;
    assign dout_data    = dout_data_r;
    assign dout_eop     = dout_eop_r;
    assign dout_partial = dout_partial_r;
    assign plane_index  = cnt_r;

endmodule

// File: tb/tb_alt_vipvfr131_common_plane_packer.sv
// Testbench for alt_vipvfr131_common_plane_packer: an N=3 instance with a
// queue-based reference model and an N=1 instance fed the same input stream
// with downstream always ready.
module tb_alt_vipvfr131_common_plane_packer;

    localparam int BPS = 8;
    localparam int N   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        = 1'b0;
    logic          sclr       = 1'b0;
    logic          din_valid  = 1'b0;
    logic [7:0]    din_data   = 8'h00;
    logic          din_eop    = 1'b0;
    logic          dout_ready = 1'b1;
    logic          rdy1       = 1'b1;

    logic          din_ready, dout_valid, dout_eop, dout_partial;
    logic [23:0]   dout_data;
    logic [1:0]    plane_index;
    logic          din_ready1, dout_valid1, dout_eop1, dout_partial1;
    logic [7:0]    dout_data1;
    logic [0:0]    plane_index1;

    alt_vipvfr131_common_plane_packer #(
        .BPS(BPS), .NUMBER_OF_COLOUR_PLANES(N), .LOG2_NUMBER_OF_COLOUR_PLANES(2)
    ) dut (
        .clk(clk), .rst(rst), .sclr(sclr),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_eop(din_eop),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_eop(dout_eop), .dout_partial(dout_partial), .plane_index(plane_index)
    );

    alt_vipvfr131_common_plane_packer #(
        .BPS(BPS), .NUMBER_OF_COLOUR_PLANES(1), .LOG2_NUMBER_OF_COLOUR_PLANES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .sclr(sclr),
        .din_valid(din_valid), .din_ready(din_ready1), .din_data(din_data), .din_eop(din_eop),
        .dout_valid(dout_valid1), .dout_ready(rdy1), .dout_data(dout_data1),
        .dout_eop(dout_eop1), .dout_partial(dout_partial1), .plane_index(plane_index1)
    );

    typedef struct { logic [23:0] data; logic eop; logic partial; } smp_t;
    typedef struct { logic [7:0] data; logic eop; } smp1_t;

    smp_t       exp_q[$];
    smp1_t      exp1_q[$];
    logic [7:0] planes[$];
    bit         m_valid  = 1'b0;
    bit         m1_valid = 1'b0;
    bit         model_on = 1'b0;
    int         checks   = 0;
    int         errors   = 0;
    smp_t       mon_e;
    smp1_t      mon_e1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: evaluated between negedge and the next posedge, when
    // the inputs for the coming edge are stable. Samples are whole lists of
    // planes; a sample closes when it holds N planes or eop arrives.
    task automatic model_step();
        logic        exp_ready;
        logic [23:0] d;
        smp_t        s;
        smp1_t       s1;
        chk("dout_valid", dout_valid, m_valid);
        chk("dout_valid_n1", dout_valid1, m1_valid);
        chk("plane_index", plane_index, planes.size());
        chk("din_ready_n1", din_ready1, rst);
        if (!rst || sclr) begin
            if (!rst) chk("din_ready_in_reset", din_ready, 1'b0);
            else      chk("din_ready", din_ready, !m_valid || dout_ready);
            planes.delete();
            exp_q.delete();
            exp1_q.delete();
            m_valid  = 1'b0;
            m1_valid = 1'b0;
        end else begin
            exp_ready = !m_valid || dout_ready;
            chk("din_ready", din_ready, exp_ready);
            if (din_valid && exp_ready) begin
                planes.push_back(din_data);
                if (planes.size() == N || din_eop) begin
                    d = 24'h000000;
                    for (int i = 0; i < planes.size(); i++) d[8*i +: 8] = planes[i];
                    s.data    = d;
                    s.eop     = din_eop;
                    s.partial = din_eop && (planes.size() < N);
                    exp_q.push_back(s);
                    planes.delete();
                    m_valid = 1'b1;
                end else if (m_valid && dout_ready) begin
                    m_valid = 1'b0;
                end
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
            if (din_valid) begin
                s1.data = din_data;
                s1.eop  = din_eop;
                exp1_q.push_back(s1);
                m1_valid = 1'b1;
            end else begin
                m1_valid = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (model_on) model_step();
        end
    end

    // Monitor: pops the expected sample whenever an output handshake is due.
    always @(negedge clk) begin
        if (model_on) begin
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_sample got %0h expected none", dout_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dout_data", dout_data, mon_e.data);
                    chk("dout_eop", dout_eop, mon_e.eop);
                    chk("dout_partial", dout_partial, mon_e.partial);
                end
            end
            if (dout_valid1) begin
                if (exp1_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_sample_n1 got %0h expected none", dout_data1);
                end else begin
                    mon_e1 = exp1_q.pop_front();
                    chk("dout_data_n1", dout_data1, mon_e1.data);
                    chk("dout_eop_n1", dout_eop1, mon_e1.eop);
                    chk("dout_partial_n1", dout_partial1, 1'b0);
                    chk("plane_index_n1", plane_index1, 1'b0);
                end
            end
        end
    end

    // Present one beat and hold it until the N=3 instance accepts it.
    task automatic send(input logic [7:0] d, input logic e);
        bit acc_b = 1'b0;
        din_valid = 1'b1;
        din_data  = d;
        din_eop   = e;
        for (int t = 0; t < 100 && !acc_b; t++) begin
            @(negedge clk);
            acc_b = din_ready;
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        din_eop   = 1'b0;
        chk("send_accepted", acc_b, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        idle(3);
        model_on = 1'b1;
        chk("reset_data", dout_data, 24'h000000);
        chk("reset_eop", dout_eop, 1'b0);
        chk("reset_partial", dout_partial, 1'b0);
        chk("reset_plane_index", plane_index, 2'd0);
        rst = 1'b1;
        idle(1);

        // Basic three-plane sample.
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        chk("t1_valid", dout_valid, 1'b1);
        chk("t1_data", dout_data, 24'h332211);
        idle(2);

        // Back-to-back samples.
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
        idle(2);

        // Eop flush of a partial sample.
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        chk("t3_data", dout_data, 24'h00BBAA);
        chk("t3_eop", dout_eop, 1'b1);
        chk("t3_partial", dout_partial, 1'b1);
        chk("t3_plane_index", plane_index, 2'd0);
        idle(2);

        // Downstream stall with a beat waiting.
        dout_ready = 1'b0;
        send(8'h9A, 1'b0); send(8'h9B, 1'b0); send(8'h9C, 1'b0);
        fork
            send(8'hC1, 1'b0);
            begin
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #1;
                    chk("stall_data", dout_data, 24'h9C9B9A);
                    chk("stall_din_ready", din_ready, 1'b0);
                end
                dout_ready = 1'b1;
            end
        join
        send(8'hC2, 1'b0); send(8'hC3, 1'b0);
        idle(2);

        // Soft clear mid-sample.
        send(8'h77, 1'b0);
        sclr = 1'b1;
        idle(1);
        sclr = 1'b0;
        chk("sclr_plane_index", plane_index, 2'd0);
        chk("sclr_valid", dout_valid, 1'b0);
        chk("sclr_data", dout_data, 24'h000000);
        send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
        chk("t5_data", dout_data, 24'h665544);
        idle(2);

        // Reset while an output is pending.
        dout_ready = 1'b0;
        send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0);
        idle(1);
        rst = 1'b0;
        idle(2);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_din_ready", din_ready, 1'b0);
        chk("rst_data", dout_data, 24'h000000);
        rst = 1'b1;
        dout_ready = 1'b1;
        idle(1);

        // Single-plane build.
        send(8'h7E, 1'b0);
        chk("n1_data", dout_data1, 8'h7E);
        chk("n1_partial", dout_partial1, 1'b0);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            dout_ready = ($urandom_range(3) != 0);
            din_valid  = 1'($urandom_range(1));
            din_data   = 8'($urandom);
            din_eop    = ($urandom_range(4) == 0);
            sclr       = ($urandom_range(40) == 0);
        end
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        din_eop    = 1'b0;
        sclr       = 1'b0;
        dout_ready = 1'b1;
        idle(4);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_queue_n1", exp1_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alt_vipvfr131_common_plane_packer.md
Name: alt_vipvfr131_common_plane_packer

Overview:
- Converts a colour-plane-sequential pixel stream (one plane per beat) into a colour-plane-parallel stream (one full sample per beat).
- Sits directly downstream of the common sample counter in the video input path.
- Its internal plane counter plays the same role as the sample counter's count_valids.
- Valid/ready handshake on both sides. End-of-packet flushes a partially filled sample.

Parameters:
- BPS, 8: bits per colour plane.
- NUMBER_OF_COLOUR_PLANES, 3: planes per sample (N), 1..4.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2: counter width, >= 1 and >= ceil(log2 N).

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- sclr  in  1  synchronous clear, active-high; applied at packet boundaries.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input beat accepted when din_valid & din_ready.
- din_data  in  BPS  one colour plane.
- din_eop  in  1  last beat of packet.
- dout_valid  out  1  parallel sample valid.
- dout_ready  in  1  downstream accepts sample.
- dout_data  out  BPS*N  packed sample; plane p in bits [p*BPS +: BPS], plane 0 in the LSBs.
- dout_eop  out  1  sample carries end of packet.
- dout_partial  out  1  sample was flushed by eop before all N planes arrived.
- plane_index  out  LOG2  index of the next plane expected (the counter value).

Behaviour:
- State:
  - plane counter cnt.
  - accumulation register acc (BPS*(N-1) bits; lanes 0..N-2).
  - output register: dout_data, dout_eop, dout_partial, dout_valid.
- Reset (rst=0 at a clock edge):
  - cnt=0, acc=0, dout_valid=0, dout_data=0, dout_eop=0, dout_partial=0.
  - din_ready is forced 0 while rst=0.
- din_ready = !dout_valid | dout_ready (combinational from dout_ready). It does not depend on din_* and is never asserted while rst=0.
- Accepted beat, cnt < N-1 and din_eop=0:
  - acc lane cnt <= din_data; cnt <= cnt+1.
  - No output change, except that an output handshake in the same cycle clears dout_valid.
- Completing beat (cnt == N-1, or din_eop=1):
  - dout_data <= acc lanes 0..cnt-1, din_data in lane cnt, zeros in lanes above cnt.
  - dout_valid <= 1; dout_eop <= din_eop; dout_partial <= din_eop & (cnt != N-1).
  - cnt <= 0; acc <= 0.
- Latency: dout_valid rises the cycle after the completing beat is accepted.
- Throughput: one plane per cycle while dout_ready=1. An output handshake and a completing input beat in the same cycle load the new sample with no bubble.
- Output handshake with no completing input: dout_valid <= 0. dout_data, dout_eop and dout_partial hold their values.
- dout_valid=1 & dout_ready=0: all dout_* hold stable, din_ready=0, cnt and acc hold.
- N==1: every accepted beat is completing; cnt and plane_index stay 0; dout_partial always 0.
- sclr=1 (rst=1):
  - Same effect as reset on cnt, acc, dout_valid, dout_eop and dout_partial.
  - dout_data is also cleared to 0.
  - An input beat in the same cycle is dropped, though din_ready still follows its normal equation.
  - sclr has priority over every other event.
- Reset or sclr mid-sample discards partial planes; there is no flush.
- cnt never exceeds N-1; wrap is N-1 -> 0 on a completing beat only.
- din_eop on plane N-1 is a normal completion with dout_partial=0.

Test Plan:
- N=3, BPS=8, dout_ready=1; planes 0x11,0x22,0x33 on consecutive cycles -> dout_valid one cycle after third beat, dout_data=0x332211, partial=0, plane_index sequence 0,1,2,0.
- Back-to-back 6 beats 0x01..0x06, dout_ready=1 -> samples 0x030201 and 0x060504 with no bubble; din_ready constantly 1.
- Beats 0xAA,0xBB with din_eop on 0xBB -> dout_data=0x00BBAA, dout_eop=1, dout_partial=1, cnt returns to 0.
- Sample pending with dout_ready=0 for 4 cycles -> din_ready=0, dout_data stable, no beat lost; releasing dout_ready re-enables input the same cycle.
- sclr asserted after 1 plane accepted (cnt=1) -> next cycle cnt=0, dout_valid=0; following 3 beats 0x44,0x55,0x66 yield 0x665544.
- rst low during pending output -> dout_valid=0 and din_ready=0 while rst=0. N=1 build: beat 0x7E -> dout_data=0x7E next cycle, partial=0.
